// File: rtl/mux_pkg.sv
// mux_pkg
// Shared types and constants for the mux_scan_nto1 block.
//   mux_state_t  : sequencer state (IDLE, SCAN, DONE)
//   MODE_MANUAL  : value of `mode` selecting manual channel select
//   MODE_SCAN    : value of `mode` selecting the automatic scan
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } mux_state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage : mux_pkg

// File: rtl/mux_nto1.sv
// mux_nto1
// Combinational N-to-1 word selector.
//   data_in  [CHANNELS*WIDTH] : channel k at [k*WIDTH +: WIDTH]
//   sel      [SEL_W]          : channel index
//   word     [WIDTH]          : selected channel, zero when sel is out of range
//   in_range                  : 1 when sel < CHANNELS
module mux_nto1 #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          word,
    output logic                      in_range
);

    // An explicit per-channel compare keeps non-power-of-two channel counts
    // safe: unused select codes match nothing and leave the word at zero.
    always_comb begin
        word     = '0;
        in_range = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SEL_W'(k)) begin
                word     = data_in[k*WIDTH +: WIDTH];
                in_range = 1'b1;
            end
        end
    end

endmodule : mux_nto1

// File: rtl/mux_scan_nto1.sv
// mux_scan_nto1
// Registered N-to-1 multiplexer with a built-in channel scan sequencer.
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   data_in     : CHANNELS words of WIDTH bits, channel k at [k*WIDTH +: WIDTH]
//   mode        : 0 = manual select via sel_in, 1 = scan (armed by start)
//   sel_in      : manual channel select
//   start       : begins a scan when idle with mode = 1
//   out         : registered selected word
//   out_sel     : channel index currently on out
//   out_valid   : out/out_sel carry a freshly sampled channel this cycle
//   busy        : scan in progress
//   done        : one-cycle pulse when a scan completes
//
// Output qualification: out_valid is a single-cycle strobe with no back
// pressure. In manual mode it is high every cycle the select is in range;
// in scan mode it is high only on the first cycle of each channel's dwell.
// The consumer must capture out/out_sel in any cycle where out_valid is high.
module mux_scan_nto1
    import mux_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = $clog2(CHANNELS),
    parameter int DWELL    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      start,
    output logic [WIDTH-1:0]          out,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      done
);

    localparam int DW_W = ($clog2(DWELL + 1) < 1) ? 1 : $clog2(DWELL + 1);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);
    localparam logic [DW_W-1:0]  LAST_DW = DW_W'(DWELL - 1);

    mux_state_t        state, state_next;
    logic [SEL_W-1:0]  ch_cnt, ch_next;
    logic [DW_W-1:0]   dw_cnt, dw_next;

    logic [WIDTH-1:0]  out_next;
    logic [SEL_W-1:0]  out_sel_next;
    logic              valid_next;
    logic              busy_next;
    logic              done_next;

    logic [SEL_W-1:0]  mux_sel;
    logic [WIDTH-1:0]  mux_word;
    logic              mux_in_range;

    // Single selector shared by both paths: the scan counter owns it while
    // scanning, the manual select otherwise.
    assign mux_sel = (state == SCAN) ? ch_cnt : sel_in;

    mux_nto1 #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_mux (
        .data_in  (data_in),
        .sel      (mux_sel),
        .word     (mux_word),
        .in_range (mux_in_range)
    );

    // Outputs are registered, so they trail the state by one edge: the SCAN
    // state entered at the start edge produces channel 0 and busy on the
    // following edge, and the DONE state produces the done pulse while the
    // state itself is already back in IDLE.
    always_comb begin
        state_next   = state;
        ch_next      = ch_cnt;
        dw_next      = dw_cnt;
        out_next     = out;
        out_sel_next = out_sel;
        valid_next   = 1'b0;
        busy_next    = 1'b0;
        done_next    = 1'b0;

        case (state)
            IDLE: begin
                if (mode == MODE_SCAN) begin
                    if (start) begin
                        state_next = SCAN;
                        ch_next    = '0;
                        dw_next    = '0;
                    end
                end else begin
                    out_next     = mux_word;
                    out_sel_next = sel_in;
                    valid_next   = mux_in_range;
                end
            end

            SCAN: begin
                busy_next = 1'b1;
                // Sample the channel only on the first dwell cycle and hold it.
                if (dw_cnt == '0) begin
                    out_next     = mux_word;
                    out_sel_next = ch_cnt;
                    valid_next   = 1'b1;
                end
                if (dw_cnt == LAST_DW) begin
                    dw_next = '0;
                    if (ch_cnt == LAST_CH) begin
                        ch_next    = '0;
                        state_next = DONE;
                    end else begin
                        ch_next = ch_cnt + 1'b1;
                    end
                end else begin
                    dw_next = dw_cnt + 1'b1;
                end
            end

            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ch_cnt    <= '0;
            dw_cnt    <= '0;
            out       <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            ch_cnt    <= ch_next;
            dw_cnt    <= dw_next;
            out       <= out_next;
            out_sel   <= out_sel_next;
            out_valid <= valid_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

endmodule : mux_scan_nto1
